// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation.
// Latency: WIDTH+1 cycles from accepting edge to done; one result per WIDTH+3 cycles back-to-back.
// Backpressure: start is taken only while ready; ignored in RUN/DONE, no queuing.
module booth_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [WIDTH+1:0]   m_reg;
    logic [WIDTH+1:0]   acc;
    logic [WIDTH:0]     q_reg;
    logic               qm1;
    logic [CW-1:0]      cnt;

    logic [WIDTH+1:0]   m_ext;
    logic [WIDTH:0]     q_ext;
    logic [WIDTH+1:0]   sum;
    logic [2*WIDTH+3:0] shifted;

    // Unsigned operands get a zero top bit so the Booth recoding treats them as non-negative.
    always_comb begin
        m_ext = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
        q_ext = {signed_mode & b[WIDTH-1], b};
    end

    always_comb begin
        case ({q_reg[0], qm1})
            2'b01:   sum = acc + m_reg;
            2'b10:   sum = acc - m_reg;
            default: sum = acc;
        endcase
        // {sum,q,qm1} shifted right arithmetically: replicate sum's sign, drop old qm1.
        shifted = {sum[WIDTH+1], sum, q_reg};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            m_reg   <= '0;
            acc     <= '0;
            q_reg   <= '0;
            qm1     <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        q_reg <= q_ext;
                        m_reg <= m_ext;
                        qm1   <= 1'b0;
                        cnt   <= CNT_INIT;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc   <= shifted[2*WIDTH+3:WIDTH+2];
                    q_reg <= shifted[WIDTH+1:1];
                    qm1   <= shifted[0];
                    cnt   <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) begin
                        product <= shifted[2*WIDTH:1];
                        state   <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready = (state == S_IDLE);
    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and randomized bench for booth_mul_seq at WIDTH=16 and WIDTH=8.
module tb_booth_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start16, sm16, ready16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] prod16;
    logic        start8, sm8, ready8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb16[$];
    logic [63:0] sb8[$];

    booth_mul_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .ready(ready16), .busy(busy16), .done(done16), .product(prod16)
    );

    booth_mul_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .ready(ready8), .busy(busy8), .done(done8), .product(prod8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input int w, input logic sm,
                                            input logic [31:0] x, input logic [31:0] y);
        longint xs, ys, p, mask;
        mask = (longint'(1) << w) - 1;
        xs = longint'(x) & mask;
        ys = longint'(y) & mask;
        if (sm && xs[w-1]) xs = xs - (longint'(1) << w);
        if (sm && ys[w-1]) ys = ys - (longint'(1) << w);
        p = xs * ys;
        return 64'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    function automatic logic get_ready(input int w);
        return (w == 16) ? ready16 : ready8;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 16) ? done16 : done8;
    endfunction

    function automatic logic [63:0] get_prod(input int w);
        return (w == 16) ? 64'(prod16) : 64'(prod8);
    endfunction

    task automatic wait_ready(input int w, input string tag);
        int n = 0;
        @(negedge clk);
        while (!get_ready(w) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!get_ready(w)) check({tag, "_ready_timeout"}, 64'(get_ready(w)), 64'd1);
    endtask

    task automatic drive_start(input int w, input logic sm, input logic [31:0] x, input logic [31:0] y);
        if (w == 16) begin
            start16 = 1'b1; sm16 = sm; a16 = x[15:0]; b16 = y[15:0];
            sb16.push_back(ref_mul(16, sm, x, y));
        end else begin
            start8 = 1'b1; sm8 = sm; a8 = x[7:0]; b8 = y[7:0];
            sb8.push_back(ref_mul(8, sm, x, y));
        end
    endtask

    // One full operation: accept, scramble the inputs, wait for done, check latency and product.
    task automatic do_op(input int w, input logic sm, input logic [31:0] x, input logic [31:0] y,
                         input string tag, input logic chk_lat);
        int lat = 0;
        logic [63:0] exp;
        wait_ready(w, tag);
        drive_start(w, sm, x, y);
        @(posedge clk);
        #1;
        start16 = 1'b0; start8 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
        a8  = 8'($urandom);  b8  = 8'($urandom);  sm8  = 1'($urandom);
        while (!get_done(w) && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (chk_lat) check({tag, "_latency"}, 64'(lat), 64'(w + 1));
        exp = (w == 16) ? sb16.pop_front() : sb8.pop_front();
        check({tag, "_product"}, get_prod(w), exp);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        int ndone;
        int done_at;
        int t[3];
        logic [63:0] exp;

        rst = 1'b1;
        start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        start8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
        #12;
        check("reset_ready", 64'(ready16), 64'd1);
        check("reset_busy",  64'(busy16),  64'd0);
        check("reset_done",  64'(done16),  64'd0);
        check("reset_product", 64'(prod16), 64'd0);
        check("reset_product8", 64'(prod8), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed corner cases.
        do_op(16, 1'b1, 32'd20,    32'hFFE2, "s16_pos_neg", 1'b1);
        check("s16_pos_neg_const", get_prod(16), 64'hFFFFFDA8);
        do_op(16, 1'b0, 32'hFFFF,  32'hFFFF, "u16_max", 1'b1);
        check("u16_max_const", get_prod(16), 64'hFFFE0001);
        do_op(16, 1'b1, 32'hFFFF,  32'hFFFF, "s16_m1_m1", 1'b1);
        check("s16_m1_m1_const", get_prod(16), 64'h00000001);
        do_op(16, 1'b1, 32'h8000,  32'h8000, "s16_min_min", 1'b1);
        check("s16_min_min_const", get_prod(16), 64'h40000000);
        do_op(16, 1'b1, 32'h8000,  32'h0001, "s16_min_one", 1'b1);
        check("s16_min_one_const", get_prod(16), 64'hFFFF8000);
        do_op(16, 1'b0, 32'h8000,  32'h8000, "u16_msb_msb", 1'b1);
        do_op(16, 1'b1, 32'h0000,  32'h7FFF, "s16_zero", 1'b0);
        do_op(8,  1'b1, 32'h80,    32'd127,  "s8_min_max", 1'b1);
        check("s8_min_max_const", get_prod(8), 64'hC080);
        do_op(8,  1'b0, 32'hFF,    32'hFF,   "u8_max", 1'b1);

        // Start pulses during RUN must be ignored.
        wait_ready(16, "run_ignore");
        drive_start(16, 1'b1, 32'h1234, 32'hF00D);
        ndone = 0;
        done_at = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start16 = (i == 4 || i == 11);
            a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
            @(posedge clk);
            #1;
            if (done16) begin
                ndone++;
                done_at = i;
            end
        end
        start16 = 1'b0;
        exp = sb16.pop_front();
        check("run_ignore_done_count", 64'(ndone), 64'd1);
        check("run_ignore_latency", 64'(done_at), 64'd17);
        check("run_ignore_product", 64'(prod16), exp);

        // Continuous start: one done every WIDTH+3 cycles.
        wait_ready(16, "cont");
        start16 = 1'b1; sm16 = 1'b0; a16 = 16'd300; b16 = 16'd7;
        exp = ref_mul(16, 1'b0, 32'd300, 32'd7);
        ndone = 0;
        for (int i = 0; i < 100 && ndone < 3; i++) begin
            @(posedge clk);
            #1;
            if (done16) begin
                t[ndone] = cyc;
                ndone++;
                check("cont_product", 64'(prod16), exp);
            end
        end
        @(negedge clk);
        start16 = 1'b0;
        check("cont_done_count", 64'(ndone), 64'd3);
        check("cont_period_1", 64'(t[1] - t[0]), 64'd19);
        check("cont_period_2", 64'(t[2] - t[1]), 64'd19);

        // Asynchronous reset in the middle of RUN.
        wait_ready(16, "rst_mid");
        drive_start(16, 1'b1, 32'h0123, 32'h0456);
        void'(sb16.pop_back());
        @(posedge clk);
        #1;
        start16 = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("rst_mid_busy_before", 64'(busy16), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_ready", 64'(ready16), 64'd1);
        check("rst_mid_busy",  64'(busy16),  64'd0);
        check("rst_mid_done",  64'(done16),  64'd0);
        check("rst_mid_product", 64'(prod16), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done16) ndone++;
        end
        check("rst_mid_no_done", 64'(ndone), 64'd0);
        do_op(16, 1'b1, 32'hFF9C, 32'd250, "rst_mid_next", 1'b1);

        // Randomized pairs against the reference model.
        for (int i = 0; i < 1000; i++)
            do_op(8, 1'b1, 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), "rand8_s", 1'b0);
        for (int i = 0; i < 1000; i++)
            do_op(8, 1'b0, 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), "rand8_u", 1'b0);
        for (int i = 0; i < 150; i++)
            do_op(16, 1'($urandom), 32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)), "rand16", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
